rst_seq_gen: RTL and testbench

//  Reset generator and sequencer that produces the resets consumed by our sync- and async-reset flops.

---
 rtl/rst_seq_pkg.sv | 29 ++
 rtl/rst_sync_chain.sv | 27 ++
 rtl/rst_seq_gen.sv | 125 ++++++++++++
 tb/tb_rst_seq_gen.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rst_seq_pkg : state encoding, helpers and parameter checks for rst_seq  |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
package rst_seq_pkg;

  localparam logic [2:0] S_RESET   = 3'd0;
  localparam logic [2:0] S_HOLD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_SWRST   = 3'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`ifndef RST_SEQ_CHECK
// Elaboration-time guard: expands to a labelled generate-if that errors out on an illegal value.
`define RST_SEQ_CHECK(cond, label) \
  if (!(cond)) begin : label \
    $error("rst_seq_gen: illegal parameter value"); \
  end
`endif
`default_nettype wire

// File: rtl/rst_sync_chain.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rst_sync_chain : N_STAGE-flop reset synchronizer, async clear/sync set  |
// | Revision       : 1.0                                                    |
// +-------------------------------------------------------------------------+
module rst_sync_chain #(
  parameter int N_STAGE = 2
) (
  input  logic clk,
  input  logic rstn,
  output logic sync_out
);

  logic [N_STAGE-1:0] sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= '0;
    end else begin
      sync <= {sync[N_STAGE-2:0], 1'b1};
    end
  end

  assign sync_out = sync[N_STAGE-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq_gen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rst_seq_gen : synchronized, held-off and staggered reset release        |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int N_STAGE     = 2,
  parameter int N_OUT       = 4,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 4,
  parameter int SW_RST_CYC  = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_sw_rst,
  output logic [N_OUT-1:0] o_rstn,
  output logic             o_done
);

  `RST_SEQ_CHECK(N_STAGE >= 2, g_chk_stage)
  `RST_SEQ_CHECK((N_OUT >= 1) && (N_OUT <= 32), g_chk_out)
  `RST_SEQ_CHECK(HOLD_CYC >= 1, g_chk_hold)
  `RST_SEQ_CHECK(STAGGER_CYC >= 1, g_chk_stagger)
  `RST_SEQ_CHECK(SW_RST_CYC >= 1, g_chk_swrst)

  localparam int CNT_W = $clog2(max3(HOLD_CYC, SW_RST_CYC, STAGGER_CYC) + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] SWRST_LAST   = CNT_W'(SW_RST_CYC - 1);
  localparam logic [N_OUT-1:0] FIRST_BIT    = N_OUT'(1);

  // A single output is fully released on the first release edge, so skip S_RELEASE.
  localparam logic [2:0] ENTRY_STATE = (N_OUT == 1) ? S_RUN : S_RELEASE;
  localparam logic       ENTRY_DONE  = (N_OUT == 1);

  logic             synced;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [N_OUT-1:0] rst_q;
  logic             done_q;
  logic [N_OUT-1:0] rel_next;

  rst_sync_chain #(
    .N_STAGE (N_STAGE)
  ) u_sync (
    .clk      (i_clk),
    .rstn     (i_rstn),
    .sync_out (synced)
  );

  // Released bits are always a contiguous run from bit 0, so release the next one by shifting in a 1.
  assign rel_next = (rst_q << 1) | FIRST_BIT;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= S_RESET;
      cnt    <= '0;
      rst_q  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          if (synced) begin
            state <= S_HOLD;
            cnt   <= '0;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state  <= ENTRY_STATE;
            cnt    <= '0;
            rst_q  <= FIRST_BIT;
            done_q <= ENTRY_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt == STAGGER_LAST) begin
            cnt   <= '0;
            rst_q <= rel_next;
            if (rel_next[N_OUT-1]) begin
              state  <= S_RUN;
              done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (i_sw_rst) begin
            state  <= S_SWRST;
            cnt    <= '0;
            rst_q  <= '0;
            done_q <= 1'b0;
          end
        end
        S_SWRST: begin
          if (cnt == SWRST_LAST) begin
            state  <= ENTRY_STATE;
            cnt    <= '0;
            rst_q  <= FIRST_BIT;
            done_q <= ENTRY_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_RESET;
          cnt    <= '0;
          rst_q  <= '0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_rstn = rst_q;
  assign o_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_gen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_rst_seq_gen : directed self-checking bench for rst_seq_gen defaults  |
// | Revision       : 1.0                                                    |
// +-------------------------------------------------------------------------+
module tb_rst_seq_gen;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b1;
  logic       rstn   = 1'b0;
  logic       sw_rst = 1'b0;
  logic [3:0] rstn_out;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  rst_seq_gen #(
    .N_STAGE     (2),
    .N_OUT       (4),
    .HOLD_CYC    (16),
    .STAGGER_CYC (4),
    .SW_RST_CYC  (8)
  ) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_sw_rst (sw_rst),
    .o_rstn   (rstn_out),
    .o_done   (done)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Power-on release: bit k high once edge >= 19 + 4k.
  function automatic logic [3:0] exp_po(input int e);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) if (e >= 19 + 4 * k) r[k] = 1'b1;
    return r;
  endfunction

  // Software-reset release: bit k high once d >= 8 + 4k edges after the trigger edge.
  function automatic logic [3:0] exp_sw(input int d);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) if (d >= 8 + 4 * k) r[k] = 1'b1;
    return r;
  endfunction

  // Releases i_rstn and checks edges 1..32; sw_rst pulses on edge sw_edge (0 = never).
  task automatic run_po(input string tag, input int sw_edge);
    rstn = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      sw_rst = (e == sw_edge);
      step(1);
      check($sformatf("%s_rstn_e%0d", tag, e), 32'(rstn_out), 32'(exp_po(e)));
      check($sformatf("%s_done_e%0d", tag, e), 32'(done), 32'(e >= 31));
    end
    sw_rst = 1'b0;
  endtask

  initial begin
    // reset state
    step(3);
    check("reset_rstn", 32'(rstn_out), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    // 1: power-on sequence
    run_po("po", 0);

    // 2: asynchronous assertion with the clock stopped
    clk_en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("async_rstn", 32'(rstn_out), 32'h0);
    check("async_done", 32'(done), 32'h0);
    #3 clk_en = 1'b1;
    step(2);
    check("async_hold_rstn", 32'(rstn_out), 32'h0);

    // 3: reset dropped mid-release, then full restart
    rstn = 1'b1;
    step(24);
    check("midrel_e24", 32'(rstn_out), 32'h3);
    #2 rstn = 1'b0;
    #1;
    check("midrel_drop_rstn", 32'(rstn_out), 32'h0);
    check("midrel_drop_done", 32'(done), 32'h0);
    step(3);
    check("midrel_low3", 32'(rstn_out), 32'h0);
    run_po("restart", 0);

    // 4: software reset pulse in S_RUN
    sw_rst = 1'b1;
    step(1);
    sw_rst = 1'b0;
    check("sw_t_rstn", 32'(rstn_out), 32'h0);
    check("sw_t_done", 32'(done), 32'h0);
    for (int d = 1; d <= 21; d++) begin
      step(1);
      check($sformatf("sw_rstn_d%0d", d), 32'(rstn_out), 32'(exp_sw(d)));
      check($sformatf("sw_done_d%0d", d), 32'(done), 32'(d >= 20));
    end

    // 5: sw pulse during S_HOLD ignored, then level-held retrigger, then rstn during S_SWRST
    rstn = 1'b0;
    step(2);
    run_po("holdign", 11);
    sw_rst = 1'b1;
    step(1);
    check("held_t0", 32'(rstn_out), 32'h0);
    step(20);
    check("held_d20_rstn", 32'(rstn_out), 32'hF);
    check("held_d20_done", 32'(done), 32'h1);
    step(1);
    check("held_d21_rstn", 32'(rstn_out), 32'h0);
    check("held_d21_done", 32'(done), 32'h0);
    step(20);
    check("held_d41_rstn", 32'(rstn_out), 32'hF);
    check("held_d41_done", 32'(done), 32'h1);
    step(1);
    check("held_d42_rstn", 32'(rstn_out), 32'h0);
    step(3);
    #2 rstn = 1'b0;
    #1;
    check("swrst_drop_rstn", 32'(rstn_out), 32'h0);
    check("swrst_drop_done", 32'(done), 32'h0);
    step(2);
    check("swrst_low_sw_rstn", 32'(rstn_out), 32'h0);
    sw_rst = 1'b0;
    run_po("postsw", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
